grad_update: RTL and testbench

- Backward-pass counterpart to the squared-error loss stage of the on-chip training datapath.
- On a start strobe, captures predicted output, target and input activations, and forms error e = predicted - target, i.e. half of d(loss)/dy.
- Walks the weight register file one weight per cycle, applying w_k <= sat(w_k - ((2*e*x_k) >>> LR_SHIFT)).
- Holds the weights and exposes them to the forward datapath; supports direct weight loading while idle.

---
 rtl/grad_update_pkg.sv | 24 ++
 rtl/grad_update_if.sv | 34 +++
 rtl/grad_delta_calc.sv | 34 +++
 rtl/grad_update.sv | 114 +++++++++++
 tb/tb_grad_update.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/grad_update_pkg.sv
// Shared training-datapath definitions: update FSM encoding, default widths that
// match the loss stage, and a saturating width-reduction helper.
package grad_update_pkg;

    typedef enum logic [0:0] {StIdle, StUpd} state_e;

    localparam int unsigned DefWWidth    = 8;
    localparam int unsigned DefXWidth    = 4;
    localparam int unsigned DefPredWidth = 21;
    localparam int unsigned DefLrShift   = 4;

    // Clamp a signed value into the range of a 'width'-bit two's-complement number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/grad_update_if.sv
// Control, training-data and weight-readout bundle of the gradient update stage.
interface grad_update_if
    import grad_update_pkg::*;
#(
    parameter int unsigned N_W        = 4,
    parameter int unsigned W_WIDTH    = DefWWidth,
    parameter int unsigned X_WIDTH    = DefXWidth,
    parameter int unsigned PRED_WIDTH = DefPredWidth
);
    localparam int unsigned IdxWidth = (N_W > 1) ? $clog2(N_W) : 1;

    logic                     en_i;
    logic                     start_i;
    logic [3:0]               target_i;
    logic [PRED_WIDTH-1:0]    predicted_i;
    logic [N_W*X_WIDTH-1:0]   x_i;
    logic                     wload_i;
    logic [IdxWidth-1:0]      wload_idx_i;
    logic [W_WIDTH-1:0]       wload_data_i;
    logic [N_W*W_WIDTH-1:0]   weights_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output en_i, start_i, target_i, predicted_i, x_i, wload_i, wload_idx_i, wload_data_i,
        input  weights_o, busy_o, done_o
    );

    modport slave (
        input  en_i, start_i, target_i, predicted_i, x_i, wload_i, wload_idx_i, wload_data_i,
        output weights_o, busy_o, done_o
    );

endinterface

// File: rtl/grad_delta_calc.sv
// Combinational weight step: w - ((2*e*x) >>> LR_SHIFT), saturated to the weight width.
module grad_delta_calc
    import grad_update_pkg::*;
#(
    parameter int unsigned W_WIDTH    = DefWWidth,
    parameter int unsigned X_WIDTH    = DefXWidth,
    parameter int unsigned PRED_WIDTH = DefPredWidth,
    parameter int unsigned LR_SHIFT   = DefLrShift
) (
    input  logic signed [PRED_WIDTH:0]  err_i,
    input  logic        [X_WIDTH-1:0]   x_i,
    input  logic signed [W_WIDTH-1:0]   w_i,
    output logic signed [W_WIDTH-1:0]   w_new_o
);
    localparam int unsigned ProdWidth = PRED_WIDTH + X_WIDTH + 3;

    logic signed [ProdWidth-1:0] err_ext;
    logic signed [ProdWidth-1:0] x_ext;
    logic signed [ProdWidth-1:0] prod;
    logic signed [ProdWidth-1:0] delta;
    logic signed [ProdWidth:0]   diff;

    always_comb begin
        err_ext = {{(ProdWidth - PRED_WIDTH - 1){err_i[PRED_WIDTH]}}, err_i};
        x_ext   = {{(ProdWidth - X_WIDTH){1'b0}}, x_i};
        prod    = (err_ext * x_ext) <<< 1;
        // Arithmetic shift rounds toward minus infinity.
        delta   = prod >>> LR_SHIFT;
        diff    = {{(ProdWidth + 1 - W_WIDTH){w_i[W_WIDTH-1]}}, w_i}
                - {delta[ProdWidth-1], delta};
        w_new_o = W_WIDTH'(sat_signed(64'(diff), W_WIDTH));
    end

endmodule

// File: rtl/grad_update.sv
// Gradient update stage: captures error and activations on start, then walks the
// weight file one weight per enabled cycle; weights are directly loadable while idle.
module grad_update
    import grad_update_pkg::*;
#(
    parameter int unsigned N_W        = 4,
    parameter int unsigned W_WIDTH    = DefWWidth,
    parameter int unsigned X_WIDTH    = DefXWidth,
    parameter int unsigned PRED_WIDTH = DefPredWidth,
    parameter int unsigned LR_SHIFT   = DefLrShift
) (
    input logic         clk_i,
    input logic         rst_i,
    grad_update_if.slave bus
);
    localparam int unsigned IdxWidth = (N_W > 1) ? $clog2(N_W) : 1;

    state_e                    state_q, state_d;
    logic [IdxWidth-1:0]       idx_q, idx_d;
    logic signed [W_WIDTH-1:0] w_q [N_W];
    logic signed [W_WIDTH-1:0] w_d [N_W];
    logic [X_WIDTH-1:0]        x_q [N_W];
    logic [X_WIDTH-1:0]        x_d [N_W];
    logic signed [PRED_WIDTH:0] err_q, err_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic signed [W_WIDTH-1:0] w_new;

    grad_delta_calc #(
        .W_WIDTH    (W_WIDTH),
        .X_WIDTH    (X_WIDTH),
        .PRED_WIDTH (PRED_WIDTH),
        .LR_SHIFT   (LR_SHIFT)
    ) u_delta (
        .err_i   (err_q),
        .x_i     (x_q[idx_q]),
        .w_i     (w_q[idx_q]),
        .w_new_o (w_new)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        w_d     = w_q;
        x_d     = x_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (bus.en_i) begin
            unique case (state_q)
                StIdle: begin
                    done_d = 1'b0;
                    if (bus.wload_i) begin
                        w_d[bus.wload_idx_i] = bus.wload_data_i;
                    end else if (bus.start_i) begin
                        err_d = $signed({1'b0, bus.predicted_i})
                              - $signed({{(PRED_WIDTH + 1 - 4){1'b0}}, bus.target_i});
                        for (int k = 0; k < N_W; k++) begin
                            x_d[k] = bus.x_i[k*X_WIDTH +: X_WIDTH];
                        end
                        idx_d   = '0;
                        state_d = StUpd;
                        busy_d  = 1'b1;
                    end
                end
                StUpd: begin
                    w_d[idx_q] = w_new;
                    if (idx_q == IdxWidth'(N_W - 1)) begin
                        idx_d   = '0;
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxWidth'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < N_W; k++) begin
                w_q[k] <= '0;
                x_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            w_q     <= w_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        bus.weights_o = '0;
        for (int k = 0; k < N_W; k++) begin
            bus.weights_o[k*W_WIDTH +: W_WIDTH] = w_q[k];
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;

endmodule

// File: tb/tb_grad_update.sv
// Bench for grad_update: cycle-level arithmetic model checked every cycle, directed
// scenarios pinned by hand-computed values, then randomized traffic.
module tb_grad_update;
    import grad_update_pkg::*;

    localparam int unsigned N_W = 4, W_WIDTH = 8, X_WIDTH = 4, PRED_WIDTH = 21, LR_SHIFT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    grad_update_if #(.N_W(N_W), .W_WIDTH(W_WIDTH), .X_WIDTH(X_WIDTH),
                     .PRED_WIDTH(PRED_WIDTH)) bus ();

    grad_update #(.N_W(N_W), .W_WIDTH(W_WIDTH), .X_WIDTH(X_WIDTH),
                  .PRED_WIDTH(PRED_WIDTH), .LR_SHIFT(LR_SHIFT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: weights as integers, a pass is just "next weight to visit".
    int     m_w [N_W];
    int     m_x [N_W];
    longint m_e;
    int     m_pos = -1;
    bit     m_done = 1'b0;
    bit     armed = 1'b0;

    function automatic longint floor_div(longint v);
        longint d = longint'(1) << LR_SHIFT;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic int clamp(longint v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return int'(v);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N_W; k++) m_w[k] = 0;
            m_pos  = -1;
            m_done = 1'b0;
            armed  = 1'b1;
        end else if (bus.en_i) begin
            if (m_pos < 0) begin
                m_done = 1'b0;
                if (bus.wload_i) begin
                    m_w[bus.wload_idx_i] = int'($signed(bus.wload_data_i));
                end else if (bus.start_i) begin
                    m_e = longint'(bus.predicted_i) - longint'(bus.target_i);
                    for (int k = 0; k < N_W; k++) m_x[k] = int'(bus.x_i[k*X_WIDTH +: X_WIDTH]);
                    m_pos = 0;
                end
            end else begin
                m_w[m_pos] = clamp(longint'(m_w[m_pos]) - floor_div(2 * m_e * m_x[m_pos]));
                if (m_pos == N_W - 1) begin
                    m_pos  = -1;
                    m_done = 1'b1;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [W_WIDTH-1:0] exp_w;
        if (bus.done_o === 1'b1) done_seen++;
        if (armed) begin
            for (int k = 0; k < N_W; k++) begin
                exp_w = W_WIDTH'(m_w[k]);
                total++;
                if (bus.weights_o[k*W_WIDTH +: W_WIDTH] !== exp_w) begin
                    bad++;
                    $display("FAIL model_w%0d @%0t: got %0d expected %0d", k, $time,
                             $signed(bus.weights_o[k*W_WIDTH +: W_WIDTH]), m_w[k]);
                end
            end
            total++;
            if (bus.busy_o !== (m_pos >= 0)) begin
                bad++;
                $display("FAIL model_busy @%0t: got %b expected %b", $time, bus.busy_o, m_pos >= 0);
            end
            total++;
            if (bus.done_o !== m_done) begin
                bad++;
                $display("FAIL model_done @%0t: got %b expected %b", $time, bus.done_o, m_done);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pins both the DUT and the model to a hand-computed weight.
    task automatic chk_w(input string name, input int k, input int exp);
        chk({name, "_dut"}, int'($signed(bus.weights_o[k*W_WIDTH +: W_WIDTH])), exp);
        chk({name, "_model"}, m_w[k], exp);
    endtask

    task automatic load(input int idx, input int val);
        bus.wload_i      = 1'b1;
        bus.wload_idx_i  = 2'(idx);
        bus.wload_data_i = 8'(val);
        @(negedge clk);
        bus.wload_i = 1'b0;
    endtask

    // Starts a pass and returns the number of negedges until done_o is seen (-1 on timeout).
    task automatic run_pass(input int pred, input int tgt, input logic [15:0] x,
                            input bit stall, output int lat);
        bus.predicted_i = 21'(pred);
        bus.target_i    = 4'(tgt);
        bus.x_i         = x;
        bus.start_i     = 1'b1;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (stall && c == 3) begin
                bus.en_i        = 1'b0;
                bus.predicted_i = '1;
                bus.target_i    = '0;
                bus.x_i         = '1;
            end
            if (stall && c == 6) bus.en_i = 1'b1;
            if (bus.done_o === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int d0;
        bus.en_i = 1'b1; bus.start_i = 1'b0; bus.target_i = '0; bus.predicted_i = '0;
        bus.x_i = '0; bus.wload_i = 1'b0; bus.wload_idx_i = '0; bus.wload_data_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < N_W; k++) chk_w("reset_w", k, 0);
        chk("reset_busy", int'(bus.busy_o), 0);
        chk("reset_done", int'(bus.done_o), 0);

        // Basic descent: e = 8.
        d0 = done_seen;
        run_pass(10, 2, {4'd15, 4'd3, 4'd2, 4'd1}, 1'b0, lat);
        chk("basic_latency", lat, 5);
        chk_w("basic_w0", 0, -1); chk_w("basic_w1", 1, -2);
        chk_w("basic_w2", 2, -3); chk_w("basic_w3", 3, -15);
        @(negedge clk);
        chk("basic_done_pulses", done_seen - d0, 1);

        // Negative error: delta = floor(-450/16) = -29.
        load(3, 0);
        run_pass(0, 15, {4'd15, 4'd0, 4'd0, 4'd0}, 1'b0, lat);
        chk_w("neg_w3", 3, 29); chk_w("neg_w0", 0, -1);
        chk_w("neg_w1", 1, -2); chk_w("neg_w2", 2, -3);
        @(negedge clk);

        // Saturation at both ends.
        load(0, 0);
        run_pass(2097151, 0, 16'h000F, 1'b0, lat);
        chk_w("sat_low_w0", 0, -128);
        @(negedge clk);
        load(0, 127);
        run_pass(0, 15, 16'h000F, 1'b0, lat);
        chk_w("sat_high_w0", 0, 127);
        @(negedge clk);

        // Stall and capture: e = 4, deltas floor(x/2).
        for (int r = 0; r < 2; r++) begin
            load(0, 10); load(1, -20); load(2, 30); load(3, -40);
            d0 = done_seen;
            run_pass(7, 3, {4'd8, 4'd7, 4'd6, 4'd5}, r == 1, lat);
            chk(r == 1 ? "stall_latency" : "nostall_latency", lat, r == 1 ? 8 : 5);
            chk_w("stall_w0", 0, 8); chk_w("stall_w1", 1, -23);
            chk_w("stall_w2", 2, 27); chk_w("stall_w3", 3, -44);
            @(negedge clk);
            chk("stall_done_width", int'(bus.done_o), 0);
            chk("stall_done_pulses", done_seen - d0, 1);
        end

        // Arbitration: load beats start in idle.
        bus.start_i = 1'b1;
        load(2, 55);
        bus.start_i = 1'b0;
        chk("arb_busy", int'(bus.busy_o), 0);
        chk_w("arb_w2", 2, 55);
        // Load and start during a zero-error pass are ignored.
        d0 = done_seen;
        bus.predicted_i = 21'd9; bus.target_i = 4'd9; bus.x_i = 16'hFFFF; bus.start_i = 1'b1;
        @(negedge clk);
        bus.wload_i = 1'b1; bus.wload_idx_i = 2'd1; bus.wload_data_i = 8'd99;
        repeat (3) @(negedge clk);
        bus.start_i = 1'b0; bus.wload_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_w("arb_upd_w1", 1, -23);
        chk_w("arb_upd_w2", 2, 55);
        chk("arb_upd_pulses", done_seen - d0, 1);
        chk("arb_upd_busy", int'(bus.busy_o), 0);

        // Reset after the second update aborts the pass.
        d0 = done_seen;
        bus.predicted_i = 21'd20; bus.target_i = 4'd0; bus.x_i = 16'hFFFF; bus.start_i = 1'b1;
        @(negedge clk); bus.start_i = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N_W; k++) chk_w("rstmid_w", k, 0);
        chk("rstmid_busy", int'(bus.busy_o), 0);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("rstmid_no_done", done_seen - d0, 0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            rst              = ($urandom % 150) != 0;
            bus.en_i         = ($urandom % 6) != 0;
            bus.start_i      = ($urandom % 4) == 0;
            bus.wload_i      = ($urandom % 6) == 0;
            bus.wload_idx_i  = 2'($urandom);
            bus.wload_data_i = 8'($urandom);
            bus.target_i     = 4'($urandom_range(0, 15));
            bus.predicted_i  = ($urandom % 2) ? 21'($urandom_range(0, 40))
                                              : 21'($urandom_range(0, 2097151));
            bus.x_i          = 16'($urandom);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
